// File: rtl/simd_alu_pkg.sv
// Shared types and lane helpers for the packed SIMD ALU.
// Lane helpers work on one 32-bit slice of four bytes.
package simd_alu_pkg;

  typedef enum logic [3:0] {
    OP_PADD    = 4'd0,
    OP_PADDS   = 4'd1,
    OP_PADDUS  = 4'd2,
    OP_PSUB    = 4'd3,
    OP_PSUBS   = 4'd4,
    OP_PSUBUS  = 4'd5,
    OP_PSHUFW  = 4'd6,
    OP_MOV1    = 4'd7,
    OP_MOV2    = 4'd8,
    OP_DECC    = 4'd9,
    OP_ILLEGAL = 4'd15
  } op_e;

  typedef enum logic [1:0] {
    ES_B   = 2'd0,
    ES_W   = 2'd1,
    ES_D   = 2'd2,
    ES_RSV = 2'd3
  } esize_e;

  localparam int SLICE_W     = 32;
  localparam int SLICE_BYTES = 4;
  localparam int GROUP_W     = 64;
  localparam int GROUP_WORDS = 4;

  // Bytes that begin an element (carry-in is injected there)
  function automatic logic [3:0] start_mask(input esize_e es);
    logic [3:0] m;
    case (es)
      ES_B:    m = 4'b1111;
      ES_W:    m = 4'b0101;
      default: m = 4'b0001;
    endcase
    return m;
  endfunction

  // Bytes that end an element (hold the lane's sign/carry)
  function automatic logic [3:0] top_mask(input esize_e es);
    logic [3:0] m;
    case (es)
      ES_B:    m = 4'b1111;
      ES_W:    m = 4'b1010;
      default: m = 4'b1000;
    endcase
    return m;
  endfunction

  // Broadcast each element's top-byte bit to all its bytes
  function automatic logic [3:0] spread(input logic [3:0] v,
                                        input esize_e es);
    logic [3:0] r;
    case (es)
      ES_B:    r = v;
      ES_W:    r = {v[3], v[3], v[1], v[1]};
      default: r = {4{v[3]}};
    endcase
    return r;
  endfunction

  function automatic logic any_sat(input logic [3:0] v,
                                   input esize_e es);
    return |(v & top_mask(es));
  endfunction

  function automatic logic [31:0] sat_signed(
    input logic [31:0] raw,
    input logic [31:0] a,
    input logic [3:0]  ovf,
    input esize_e      es
  );
    logic [31:0] r;
    logic [3:0]  o;
    logic [3:0]  s;
    logic [3:0]  tm;
    r  = raw;
    o  = spread(ovf, es);
    s  = spread({a[31], a[23], a[15], a[7]}, es);
    tm = top_mask(es);
    for (int k = 0; k < SLICE_BYTES; k++) begin
      if (o[k]) begin
        if (s[k]) r[8*k +: 8] = tm[k] ? 8'h80 : 8'h00;
        else      r[8*k +: 8] = tm[k] ? 8'h7F : 8'hFF;
      end
    end
    return r;
  endfunction

  // For subtract, a clear carry-out means the lane borrowed
  function automatic logic [31:0] sat_unsigned(
    input logic [31:0] raw,
    input logic [3:0]  cy,
    input logic        sub,
    input esize_e      es
  );
    logic [31:0] r;
    logic [3:0]  c;
    r = raw;
    c = spread(cy ^ {4{sub}}, es);
    for (int k = 0; k < SLICE_BYTES; k++) begin
      if (c[k]) r[8*k +: 8] = sub ? 8'h00 : 8'hFF;
    end
    return r;
  endfunction

endpackage

// File: rtl/simd_alu_pipe_lane.sv
// One 32-bit add/sub slice; carry chain cut at element starts.
// Returns raw sum plus per-byte carry-out and signed overflow.
module simd_lane_addsub
  import simd_alu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sub,
  input  esize_e      i_esize,
  output logic [31:0] o_sum,
  output logic [3:0]  o_cy,
  output logic [3:0]  o_ovf
);

  logic [3:0] w_sm;
  logic [7:0] w_bx;
  logic [8:0] w_t;
  logic       w_ci;
  logic       w_c;

  assign w_sm = start_mask(i_esize);

  always_comb begin
    o_sum = '0;
    o_cy  = '0;
    o_ovf = '0;
    w_bx  = '0;
    w_t   = '0;
    w_ci  = 1'b0;
    w_c   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      w_bx = i_b[8*k +: 8] ^ {8{i_sub}};
      w_ci = w_sm[k] ? i_sub : w_c;
      w_t  = {1'b0, i_a[8*k +: 8]} + {1'b0, w_bx} + {8'd0, w_ci};
      w_c  = w_t[8];
      o_sum[8*k +: 8] = w_t[7:0];
      o_cy[k]  = w_t[8];
      o_ovf[k] = (i_a[8*k+7] == w_bx[7]) && (w_t[7] != i_a[8*k+7]);
    end
  end

endmodule

// File: rtl/simd_alu_pipe.sv
// Two-stage packed-integer ALU with valid/ready handshake.
// Stage 1 adds/subtracts, stage 2 saturates and selects.
module simd_alu_pipe
  import simd_alu_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [1:0]        esize,
  input  logic [DATA_W-1:0] mm1,
  input  logic [DATA_W-1:0] mm2,
  input  logic [7:0]        imm8,
  input  logic [CNT_W-1:0]  ecx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] alu_res,
  output logic              sat_flag,
  output logic              ill_flag,
  input  logic              flag_clr
);

  localparam int NSL = DATA_W / SLICE_W;
  localparam int NGR = DATA_W / GROUP_W;
  localparam int NB  = DATA_W / 8;

  logic              w_s1_adv;
  logic              w_s2_adv;
  logic              w_accept;
  logic              w_xfer;
  logic              w_sub;
  logic [DATA_W-1:0] w_sum;
  logic [NB-1:0]     w_cy;
  logic [NB-1:0]     w_ovf;

  logic              r_s1_valid;
  logic [3:0]        r_s1_op;
  logic [1:0]        r_s1_es;
  logic [7:0]        r_s1_imm8;
  logic [CNT_W-1:0]  r_s1_ecx;
  logic [DATA_W-1:0] r_s1_mm1;
  logic [DATA_W-1:0] r_s1_mm2;
  logic [DATA_W-1:0] r_s1_sum;
  logic [NB-1:0]     r_s1_cy;
  logic [NB-1:0]     r_s1_ovf;

  logic              r_s2_valid;
  logic [DATA_W-1:0] r_res;
  logic              r_s2_sat;
  logic              r_s2_ill;
  logic              r_sat;
  logic              r_ill;

  assign w_s2_adv  = !r_s2_valid || out_ready;
  assign w_s1_adv  = !r_s1_valid || w_s2_adv;
  assign w_accept  = in_valid && w_s1_adv;
  assign w_xfer    = r_s2_valid && out_ready;
  assign in_ready  = w_s1_adv;
  assign out_valid = r_s2_valid;
  assign alu_res   = r_res;
  assign sat_flag  = r_sat;
  assign ill_flag  = r_ill;

  assign w_sub = (op == OP_PSUB) || (op == OP_PSUBS)
              || (op == OP_PSUBUS);

  for (genvar g = 0; g < NSL; g++) begin : g_lane
    simd_lane_addsub u_lane (
      .i_a     (mm1[SLICE_W*g +: SLICE_W]),
      .i_b     (mm2[SLICE_W*g +: SLICE_W]),
      .i_sub   (w_sub),
      .i_esize (esize_e'(esize)),
      .o_sum   (w_sum[SLICE_W*g +: SLICE_W]),
      .o_cy    (w_cy[SLICE_BYTES*g +: SLICE_BYTES]),
      .o_ovf   (w_ovf[SLICE_BYTES*g +: SLICE_BYTES])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_s1_valid <= 1'b0;
    else if (w_s1_adv) r_s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_op   <= op;
      r_s1_es   <= esize;
      r_s1_imm8 <= imm8;
      r_s1_ecx  <= ecx;
      r_s1_mm1  <= mm1;
      r_s1_mm2  <= mm2;
      r_s1_sum  <= w_sum;
      r_s1_cy   <= w_cy;
      r_s1_ovf  <= w_ovf;
    end
  end

  esize_e            w_es;
  logic              w_rsv;
  logic              w_usub;
  logic [DATA_W-1:0] w_sres;
  logic [DATA_W-1:0] w_ures;
  logic              w_ssat;
  logic              w_usat;
  logic [DATA_W-1:0] w_shuf;
  logic [DATA_W-1:0] w_res;
  logic              w_sat;
  logic              w_ill;

  assign w_es   = esize_e'(r_s1_es);
  assign w_rsv  = (w_es == ES_RSV);
  assign w_usub = (r_s1_op == OP_PSUBUS);

  always_comb begin
    w_sres = '0;
    w_ures = '0;
    w_ssat = 1'b0;
    w_usat = 1'b0;
    for (int g = 0; g < NSL; g++) begin
      w_sres[SLICE_W*g +: SLICE_W] = sat_signed(
        r_s1_sum[SLICE_W*g +: SLICE_W],
        r_s1_mm1[SLICE_W*g +: SLICE_W],
        r_s1_ovf[SLICE_BYTES*g +: SLICE_BYTES], w_es);
      w_ures[SLICE_W*g +: SLICE_W] = sat_unsigned(
        r_s1_sum[SLICE_W*g +: SLICE_W],
        r_s1_cy[SLICE_BYTES*g +: SLICE_BYTES], w_usub, w_es);
      w_ssat = w_ssat | any_sat(
        r_s1_ovf[SLICE_BYTES*g +: SLICE_BYTES], w_es);
      w_usat = w_usat | any_sat(
        r_s1_cy[SLICE_BYTES*g +: SLICE_BYTES] ^ {4{w_usub}}, w_es);
    end
  end

  // Same imm8 reorders every 64-bit group independently
  always_comb begin
    w_shuf = '0;
    for (int g = 0; g < NGR; g++) begin
      for (int i = 0; i < GROUP_WORDS; i++) begin
        case (r_s1_imm8[2*i +: 2])
          2'd0: w_shuf[GROUP_W*g+16*i +: 16] =
                  r_s1_mm2[GROUP_W*g +: 16];
          2'd1: w_shuf[GROUP_W*g+16*i +: 16] =
                  r_s1_mm2[GROUP_W*g+16 +: 16];
          2'd2: w_shuf[GROUP_W*g+16*i +: 16] =
                  r_s1_mm2[GROUP_W*g+32 +: 16];
          default: w_shuf[GROUP_W*g+16*i +: 16] =
                  r_s1_mm2[GROUP_W*g+48 +: 16];
        endcase
      end
    end
  end

  always_comb begin
    w_res = '0;
    w_sat = 1'b0;
    w_ill = 1'b0;
    case (r_s1_op)
      OP_PADD, OP_PSUB: begin
        w_ill = w_rsv;
        if (!w_rsv) w_res = r_s1_sum;
      end
      OP_PADDS, OP_PSUBS: begin
        w_ill = w_rsv;
        if (!w_rsv) begin
          w_res = w_sres;
          w_sat = w_ssat;
        end
      end
      OP_PADDUS, OP_PSUBUS: begin
        w_ill = w_rsv;
        if (!w_rsv) begin
          w_res = w_ures;
          w_sat = w_usat;
        end
      end
      OP_PSHUFW: w_res = w_shuf;
      OP_MOV1:   w_res = r_s1_mm1;
      OP_MOV2:   w_res = r_s1_mm2;
      OP_DECC:   w_res[CNT_W-1:0] = r_s1_ecx - CNT_W'(1);
      default:   w_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_s2_sat   <= 1'b0;
      r_s2_ill   <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res    <= w_res;
        r_s2_sat <= w_sat;
        r_s2_ill <= w_ill;
      end
    end
  end

  // A set on the transfer edge beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sat <= 1'b0;
      r_ill <= 1'b0;
    end else begin
      r_sat <= (r_sat & ~flag_clr) | (w_xfer & r_s2_sat);
      r_ill <= (r_ill & ~flag_clr) | (w_xfer & r_s2_ill);
    end
  end

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Directed bench for simd_alu_pipe at DATA_W=128.
// Vector table plus backpressure, flag and reset sequences.
module tb_simd_alu_pipe;
  import simd_alu_pkg::*;

  localparam int DW = 128;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    op;
  logic [1:0]    esize;
  logic [DW-1:0] mm1;
  logic [DW-1:0] mm2;
  logic [7:0]    imm8;
  logic [CW-1:0] ecx;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] alu_res;
  logic          sat_flag;
  logic          ill_flag;
  logic          flag_clr;

  always #5 clk = ~clk;

  simd_alu_pipe #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .esize     (esize),
    .mm1       (mm1),
    .mm2       (mm2),
    .imm8      (imm8),
    .ecx       (ecx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_res   (alu_res),
    .sat_flag  (sat_flag),
    .ill_flag  (ill_flag),
    .flag_clr  (flag_clr)
  );

  typedef struct {
    logic [3:0]    op;
    logic [1:0]    es;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [7:0]    imm;
    logic [CW-1:0] ecx;
    logic [DW-1:0] res;
    logic          sat;
    logic          ill;
  } vec_t;

  vec_t vq[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act,
                      input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(
    input logic [3:0] o, input logic [1:0] e,
    input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [7:0] im, input logic [CW-1:0] c,
    input logic [DW-1:0] r, input logic s, input logic il);
    vec_t v;
    v.op = o; v.es = e; v.a = a; v.b = b; v.imm = im;
    v.ecx = c; v.res = r; v.sat = s; v.ill = il;
    return v;
  endfunction

  task automatic send(input logic [3:0] o, input logic [1:0] e,
                      input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [7:0] im, input logic [CW-1:0] c);
    op = o; esize = e; mm1 = a; mm2 = b; imm8 = im; ecx = c;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    chk1({nm, "_timeout"}, out_valid, 1'b1);
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    send(v.op, v.es, v.a, v.b, v.imm, v.ecx);
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick;
      lat++;
    end
    chk({nm, "_lat"}, DW'(lat), DW'(2));
    chk({nm, "_res"}, alu_res, v.res);
    tick;
    chk1({nm, "_sat"}, sat_flag, v.sat);
    chk1({nm, "_ill"}, ill_flag, v.ill);
  endtask

  initial begin
    logic          acc;
    logic          xf;
    int            ia;
    int            got;
    int            seen;
    logic [DW-1:0] h0;

    rst = 1'b1; in_valid = 1'b0; op = '0; esize = '0;
    mm1 = '0; mm2 = '0; imm8 = '0; ecx = '0;
    out_ready = 1'b1; flag_clr = 1'b0;

    vq.push_back(mk(OP_PADDS, ES_W, 128'h8000_7FFF,
      128'hFFFF_0001, 8'h0, 32'h0, 128'h8000_7FFF, 1'b1, 1'b0));
    vq.push_back(mk(OP_PADDUS, ES_B, {16{8'hFF}}, {16{8'h01}},
      8'h0, 32'h0, {16{8'hFF}}, 1'b1, 1'b0));
    vq.push_back(mk(OP_PADD, ES_B, {16{8'hFF}}, {16{8'h01}},
      8'h0, 32'h0, 128'h0, 1'b0, 1'b0));
    vq.push_back(mk(OP_PSHUFW, ES_RSV, 128'h0,
      128'h0008_0007_0006_0005_0004_0003_0002_0001, 8'h1B, 32'h0,
      128'h0005_0006_0007_0008_0001_0002_0003_0004, 1'b0, 1'b0));
    vq.push_back(mk(OP_DECC, ES_B, {4{32'hDEAD_BEEF}},
      {4{32'hDEAD_BEEF}}, 8'h0, 32'h0, 128'hFFFF_FFFF, 1'b0, 1'b0));
    vq.push_back(mk(OP_DECC, ES_B, 128'h0, 128'h0, 8'h0, 32'd5,
      128'h4, 1'b0, 1'b0));
    vq.push_back(mk(OP_PSUBUS, ES_B, 128'h1005, 128'h2003, 8'h0,
      32'h0, 128'h0002, 1'b1, 1'b0));
    vq.push_back(mk(OP_PSUBS, ES_D, 128'h7FFF_FFFF_8000_0000,
      128'hFFFF_FFFF_0000_0001, 8'h0, 32'h0,
      128'h7FFF_FFFF_8000_0000, 1'b1, 1'b0));
    vq.push_back(mk(OP_PSUB, ES_W, 128'h0, 128'h1, 8'h0, 32'h0,
      128'hFFFF, 1'b0, 1'b0));
    vq.push_back(mk(OP_PADD, ES_D, 128'h0000_00FF_FFFF_FFFF,
      128'h0000_0001_0000_0001, 8'h0, 32'h0,
      128'h0000_0100_0000_0000, 1'b0, 1'b0));
    vq.push_back(mk(OP_MOV1, ES_B,
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
      128'h5555, 8'h0, 32'h0,
      128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 1'b0, 1'b0));
    vq.push_back(mk(OP_MOV2, ES_B, 128'h5555,
      128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 8'h0, 32'h0,
      128'hCAFE_0000_0000_0000_0000_0000_0000_BABE, 1'b0, 1'b0));
    vq.push_back(mk(4'd12, ES_B, 128'h1234, 128'h5678, 8'h0,
      32'h7, 128'h0, 1'b0, 1'b1));
    vq.push_back(mk(OP_PADDS, ES_RSV, 128'h1234, 128'h5678, 8'h0,
      32'h0, 128'h0, 1'b0, 1'b1));
    vq.push_back(mk(OP_PADDUS, ES_W, 128'hFFF0_0001,
      128'h0020_0002, 8'h0, 32'h0, 128'hFFFF_0003, 1'b1, 1'b0));
    vq.push_back(mk(OP_PADDS, ES_B, 128'h807E, 128'h0101, 8'h0,
      32'h0, 128'h817F, 1'b0, 1'b0));

    tick;
    tick;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_res", alu_res, '0);
    chk1("rst_sat", sat_flag, 1'b0);
    chk1("rst_ill", ill_flag, 1'b0);
    rst = 1'b0;
    tick;

    for (int i = 0; i < vq.size(); i++)
      run_vec(vq[i], $sformatf("v%0d", i));

    // Backpressure: four MOV2s, consumer stalled for 3 cycles
    op = OP_MOV2; esize = '0; mm2 = DW'(160);
    in_valid = 1'b1;
    ia = 0;
    got = 0;
    h0 = DW'(160);
    for (int c = 0; c < 40 && got < 4; c++) begin
      out_ready = (c >= 5);
      #1;
      acc = in_valid && in_ready;
      xf  = out_valid && out_ready;
      if (c == 2) chk1("bp_in_ready_low", in_ready, 1'b0);
      if (c >= 2 && c <= 4) begin
        chk1($sformatf("bp_hold_valid%0d", c), out_valid, 1'b1);
        chk($sformatf("bp_hold_res%0d", c), alu_res, h0);
      end
      if (xf) begin
        chk($sformatf("bp_out%0d", got), alu_res, DW'(160 + got));
        got++;
      end
      tick;
      if (acc) begin
        ia++;
        if (ia < 4) mm2 = DW'(160 + ia);
        else in_valid = 1'b0;
      end
    end
    chk("bp_count", DW'(got), DW'(4));
    chk1("bp_no_dup0", out_valid, 1'b0);
    tick;
    chk1("bp_no_dup1", out_valid, 1'b0);
    out_ready = 1'b1;

    // Sticky flags: illegal op, then clear racing a saturating set
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    send(4'd12, ES_B, '0, '0, 8'h0, 32'h0);
    wait_out("fl_ill");
    tick;
    chk1("fl_ill_set", ill_flag, 1'b1);
    chk1("fl_ill_nosat", sat_flag, 1'b0);
    send(OP_PADDS, ES_W, 128'h8000_7FFF, 128'hFFFF_0001, 8'h0, 32'h0);
    wait_out("fl_sat");
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk1("fl_set_wins", sat_flag, 1'b1);
    chk1("fl_ill_cleared", ill_flag, 1'b0);
    flag_clr = 1'b1;
    tick;
    flag_clr = 1'b0;
    chk1("fl_sat_cleared", sat_flag, 1'b0);

    // Reset while a transaction sits in stage 1
    send(OP_MOV2, ES_B, '0, 128'hDEAD, 8'h0, 32'h0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk1("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_res", alu_res, '0);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      if (out_valid) seen++;
      tick;
    end
    chk("mid_rst_dropped", DW'(seen), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
